// File: rtl/vend_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : vend_sequencer_if
// Description : Request/strobe bundle between the vend sequencer and its
//               surroundings (debouncers upstream, credit/stock registers and
//               motor drivers downstream).
//   master : drives req/id/cancel/credit/stock_empty, observes the strobes
//   slave  : the sequencer itself
//   Signals: req, id[1:0], cancel, credit[4:0] (half units), stock_empty[2:0],
//            busy, debit, debit_amt[4:0], stock_dec[2:0], motor[2:0],
//            coin_out, done, err, err_code[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface vend_sequencer_if;
  logic       req;
  logic [1:0] id;
  logic       cancel;
  logic [4:0] credit;
  logic [2:0] stock_empty;
  logic       busy;
  logic       debit;
  logic [4:0] debit_amt;
  logic [2:0] stock_dec;
  logic [2:0] motor;
  logic       coin_out;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output req, id, cancel, credit, stock_empty,
    input  busy, debit, debit_amt, stock_dec, motor, coin_out, done, err, err_code
  );

  modport slave (
    input  req, id, cancel, credit, stock_empty,
    output busy, debit, debit_amt, stock_dec, motor, coin_out, done, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vend_sequencer
// Description : Vending transaction controller. Checks a vend request against
//               id validity, stock and credit, then strobes debit/stock
//               decrement and times the dispense motor; on cancel returns the
//               credit as a train of half-unit coin pulses.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - vend_sequencer_if.slave (request inputs, strobe outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module vend_sequencer #(
  parameter int         DISPENSE_CYCLES = 8,
  parameter int         CHANGE_GAP      = 4,
  parameter logic [4:0] PRICE0          = 5'd3,
  parameter logic [4:0] PRICE1          = 5'd5,
  parameter logic [4:0] PRICE2          = 5'd6
) (
  input  wire logic          clk,
  input  wire logic          rst,
  vend_sequencer_if.slave    bus
);

  localparam int c_max_cnt = (DISPENSE_CYCLES > CHANGE_GAP) ? DISPENSE_CYCLES : CHANGE_GAP;
  localparam int c_cnt_w   = $clog2(c_max_cnt + 1);

  // The counter is tested for zero before decrementing, so loading N-1 gives
  // an N-cycle interval between the loading edge and the acting edge.
  localparam logic [c_cnt_w-1:0] c_disp_load = c_cnt_w'(DISPENSE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'(CHANGE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CHECK      = 2'd1,
    S_DISPENSE   = 2'd2,
    S_REFUND_GAP = 2'd3
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic [1:0]         r_id,        w_id_nxt;
  logic [c_cnt_w-1:0] r_cnt,       w_cnt_nxt;
  logic [4:0]         r_rem,       w_rem_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_debit,     w_debit_nxt;
  logic [4:0]         r_debit_amt, w_debit_amt_nxt;
  logic [2:0]         r_stock_dec, w_stock_dec_nxt;
  logic [2:0]         r_motor,     w_motor_nxt;
  logic               r_coin,      w_coin_nxt;
  logic               r_done,      w_done_nxt;
  logic               r_err,       w_err_nxt;
  logic [1:0]         r_err_code,  w_err_code_nxt;

  logic [4:0] w_price;
  logic [3:0] w_sold_ext;
  logic       w_sold;
  logic [2:0] w_onehot;

  always_comb begin
    case (r_id)
      2'd0:    w_price = PRICE0;
      2'd1:    w_price = PRICE1;
      default: w_price = PRICE2;
    endcase
  end

  // Id 3 is rejected before the stock test, the padding bit only keeps the
  // index in range.
  assign w_sold_ext = {1'b1, bus.stock_empty};
  assign w_sold     = w_sold_ext[r_id];
  assign w_onehot   = 3'b001 << r_id;

  always_comb begin
    w_state_nxt     = r_state;
    w_id_nxt        = r_id;
    w_cnt_nxt       = r_cnt;
    w_rem_nxt       = r_rem;
    w_busy_nxt      = r_busy;
    w_debit_nxt     = 1'b0;
    w_debit_amt_nxt = 5'd0;
    w_stock_dec_nxt = 3'b000;
    w_motor_nxt     = r_motor;
    w_coin_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_code_nxt  = r_err_code;

    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          // A simultaneous cancel is deliberately dropped.
          w_id_nxt    = bus.id;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_CHECK;
        end else if (bus.cancel && (bus.credit != 5'd0)) begin
          // First coin goes out immediately; the rest follow from the
          // snapshot so credit added during the refund is not returned.
          w_rem_nxt       = bus.credit - 5'd1;
          w_coin_nxt      = 1'b1;
          w_debit_nxt     = 1'b1;
          w_debit_amt_nxt = 5'd1;
          w_cnt_nxt       = c_gap_load;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_REFUND_GAP;
        end
      end

      S_CHECK: begin
        if (r_id == 2'd3) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = 2'b01;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = S_IDLE;
        end else if (w_sold) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = 2'b10;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = S_IDLE;
        end else if (bus.credit < w_price) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = 2'b11;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_debit_nxt     = 1'b1;
          w_debit_amt_nxt = w_price;
          w_stock_dec_nxt = w_onehot;
          w_motor_nxt     = w_onehot;
          w_cnt_nxt       = c_disp_load;
          w_state_nxt     = S_DISPENSE;
        end
      end

      S_DISPENSE: begin
        if (r_cnt == '0) begin
          w_motor_nxt = 3'b000;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_REFUND_GAP: begin
        if (r_cnt == '0) begin
          if (r_rem != 5'd0) begin
            w_coin_nxt      = 1'b1;
            w_debit_nxt     = 1'b1;
            w_debit_amt_nxt = 5'd1;
            w_rem_nxt       = r_rem - 5'd1;
            w_cnt_nxt       = c_gap_load;
          end else begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_id        <= 2'd0;
      r_cnt       <= '0;
      r_rem       <= 5'd0;
      r_busy      <= 1'b0;
      r_debit     <= 1'b0;
      r_debit_amt <= 5'd0;
      r_stock_dec <= 3'b000;
      r_motor     <= 3'b000;
      r_coin      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_id        <= w_id_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rem       <= w_rem_nxt;
      r_busy      <= w_busy_nxt;
      r_debit     <= w_debit_nxt;
      r_debit_amt <= w_debit_amt_nxt;
      r_stock_dec <= w_stock_dec_nxt;
      r_motor     <= w_motor_nxt;
      r_coin      <= w_coin_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_code  <= w_err_code_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.debit     = r_debit;
  assign bus.debit_amt = r_debit_amt;
  assign bus.stock_dec = r_stock_dec;
  assign bus.motor     = r_motor;
  assign bus.coin_out  = r_coin;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_sequencer
// Description : Directed self-checking bench for vend_sequencer: reset values,
//               accepted vends, reject priority, coin refund, collisions,
//               reset during dispense and credit boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vend_sequencer_if bus ();

  vend_sequencer #(
    .DISPENSE_CYCLES (8),
    .CHANGE_GAP      (4),
    .PRICE0          (5'd3),
    .PRICE1          (5'd5),
    .PRICE2          (5'd6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Return 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full accepted-vend sequence with timing checks. with_cancel raises cancel
  // together with req; poke fires req and cancel while the motor runs.
  task automatic run_vend(input logic [1:0] pid, input logic [4:0] amt,
                          input logic [2:0] m_exp, input bit with_cancel, input bit poke);
    bus.id     = pid;
    bus.req    = 1'b1;
    bus.cancel = with_cancel;
    tick();                                     // after edge k
    bus.req    = 1'b0;
    bus.cancel = 1'b0;
    chk("vend_busy_k",   bus.busy, 1);
    chk("vend_debit_k",  bus.debit, 0);
    chk("vend_coin_k",   bus.coin_out, 0);
    tick();                                     // after edge k+1
    chk("vend_debit",     bus.debit, 1);
    chk("vend_debit_amt", bus.debit_amt, amt);
    chk("vend_stock_dec", bus.stock_dec, m_exp);
    chk("vend_motor_on",  bus.motor, m_exp);
    chk("vend_err",       bus.err, 0);
    chk("vend_coin_k1",   bus.coin_out, 0);
    for (int j = 2; j <= 9; j++) begin
      if (poke && j == 3) begin
        bus.req    = 1'b1;
        bus.id     = 2'd2;
        bus.cancel = 1'b1;
      end
      tick();                                   // after edge k+j
      bus.req    = 1'b0;
      bus.cancel = 1'b0;
      bus.id     = pid;
      chk("vend_coin_run", bus.coin_out, 0);
      chk("vend_debit_run", bus.debit, 0);
      if (j < 9) begin
        chk("vend_motor_hold", bus.motor, m_exp);
        chk("vend_done_early", bus.done, 0);
        chk("vend_busy_hold",  bus.busy, 1);
      end else begin
        chk("vend_motor_off", bus.motor, 0);
        chk("vend_done",      bus.done, 1);
        chk("vend_busy_fall", bus.busy, 0);
      end
    end
    tick();
    chk("vend_done_pulse", bus.done, 0);
  endtask

  task automatic do_reject(input logic [1:0] pid, input logic [2:0] se,
                           input logic [4:0] cr, input logic [1:0] code);
    bus.id          = pid;
    bus.stock_empty = se;
    bus.credit      = cr;
    bus.req         = 1'b1;
    tick();
    bus.req = 1'b0;
    chk("rej_busy_k", bus.busy, 1);
    chk("rej_err_k",  bus.err, 0);
    tick();
    chk("rej_err",       bus.err, 1);
    chk("rej_code",      bus.err_code, code);
    chk("rej_debit",     bus.debit, 0);
    chk("rej_stock_dec", bus.stock_dec, 0);
    chk("rej_motor",     bus.motor, 0);
    chk("rej_busy_fall", bus.busy, 0);
    tick();
    chk("rej_err_pulse", bus.err, 0);
    chk("rej_code_hold", bus.err_code, code);
  endtask

  initial begin
    bus.req         = 1'b0;
    bus.id          = 2'd0;
    bus.cancel      = 1'b0;
    bus.credit      = 5'd0;
    bus.stock_empty = 3'b000;

    // Reset values
    tick();
    tick();
    chk("rst_busy",      bus.busy, 0);
    chk("rst_debit",     bus.debit, 0);
    chk("rst_debit_amt", bus.debit_amt, 0);
    chk("rst_stock_dec", bus.stock_dec, 0);
    chk("rst_motor",     bus.motor, 0);
    chk("rst_coin",      bus.coin_out, 0);
    chk("rst_done",      bus.done, 0);
    chk("rst_err",       bus.err, 0);
    chk("rst_err_code",  bus.err_code, 0);
    rst = 1'b0;
    tick();

    // Accepted vend: product 1, credit 8
    bus.credit = 5'd8;
    run_vend(2'd1, 5'd5, 3'b010, 1'b0, 1'b0);

    // Reject priority
    do_reject(2'd3, 3'b000, 5'd8, 2'b01);
    do_reject(2'd2, 3'b100, 5'd2, 2'b10);
    do_reject(2'd0, 3'b000, 5'd2, 2'b11);
    bus.stock_empty = 3'b000;

    // Refund of 3 half-units; credit rises mid-refund
    bus.credit = 5'd3;
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    for (int j = 0; j <= 13; j++) begin
      if (j > 0) tick();
      chk("ref_coin",      bus.coin_out, (j == 0 || j == 4 || j == 8) ? 1 : 0);
      chk("ref_debit",     bus.debit,    (j == 0 || j == 4 || j == 8) ? 1 : 0);
      chk("ref_debit_amt", bus.debit_amt,(j == 0 || j == 4 || j == 8) ? 1 : 0);
      chk("ref_done",      bus.done,     (j == 12) ? 1 : 0);
      chk("ref_busy",      bus.busy,     (j < 12) ? 1 : 0);
      if (j == 5) bus.credit = 5'd5;
    end

    // req+cancel together, then req/cancel poked during dispense
    bus.credit = 5'd8;
    run_vend(2'd0, 5'd3, 3'b001, 1'b1, 1'b1);

    // Boundary: credit exactly equals price 2
    bus.credit = 5'd6;
    run_vend(2'd2, 5'd6, 3'b100, 1'b0, 1'b0);

    // Cancel with zero credit does nothing
    bus.credit = 5'd0;
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("c0_busy",  bus.busy, 0);
    chk("c0_coin",  bus.coin_out, 0);
    chk("c0_debit", bus.debit, 0);
    tick();
    chk("c0_busy2", bus.busy, 0);
    chk("c0_done",  bus.done, 0);

    // Reset during the third motor cycle (err_code currently 11)
    bus.credit = 5'd6;
    bus.id     = 2'd2;
    bus.req    = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_motor_pre", bus.motor, 3'b100);
    rst = 1'b1;
    #1;
    chk("mr_motor",     bus.motor, 0);
    chk("mr_busy",      bus.busy, 0);
    chk("mr_debit",     bus.debit, 0);
    chk("mr_stock_dec", bus.stock_dec, 0);
    chk("mr_err_code",  bus.err_code, 0);
    chk("mr_done",      bus.done, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("mr_post_busy",  bus.busy, 0);
    chk("mr_post_debit", bus.debit, 0);
    chk("mr_post_motor", bus.motor, 0);

    // Normal vend after reset; credit exactly equals price 0
    bus.credit = 5'd3;
    run_vend(2'd0, 5'd3, 3'b001, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
